// File: rtl/counter_pkg.sv
// Shared constants and mode decode for the cascaded BCD counters.
// Pure definitions; no state, no latency, no flow control.
package counter_pkg;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] MODE_MOD10 = 4'b1001;
   localparam logic [BCD_W-1:0] MODE_MOD6  = 4'b0101;
   localparam logic [BCD_W-1:0] MODE_MOD2  = 4'b0001;

   // Maps a per-digit mode code to the highest value that digit reaches before wrapping.
   function automatic logic [BCD_W-1:0] mode_to_max(
      input logic [BCD_W-1:0] mode,
      input logic [BCD_W-1:0] default_max
   );
      logic [BCD_W-1:0] m;
      case (mode)
         MODE_MOD10: m = 4'd9;
         MODE_MOD6:  m = 4'd5;
         MODE_MOD2:  m = 4'd1;
         default:    m = default_max;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// One BCD digit with clear/load/increment; Digit updates one edge after IncIn.
// No backpressure: an increment request is always taken; carry leaves combinationally.
module bcd_up_digit
   import counter_pkg::*;
(
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Clear,
   input  logic             Load,
   input  logic [BCD_W-1:0] LoadDigit,
   input  logic             IncIn,
   input  logic [BCD_W-1:0] Max,
   output logic [BCD_W-1:0] Digit,
   output logic             AtMax,
   output logic             IncOut
);

   // ">=" rather than "==" so a digit parked above its max (mode change or raw load)
   // still wraps to 0 and carries instead of counting through 10..15.
   assign AtMax  = (Digit >= Max);
   assign IncOut = IncIn & AtMax;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Digit <= '0;
      end else if (Clear) begin
         Digit <= '0;
      end else if (Load) begin
         Digit <= LoadDigit;
      end else if (IncIn) begin
         Digit <= AtMax ? '0 : Digit + 4'd1;
      end
   end

endmodule

// File: rtl/complex_up_counter_bcd.sv
// Cascaded per-digit-modulus BCD up-counter; Count updates one edge after Enable, carries ripple within the cycle.
// No backpressure: Enable is sampled every edge; Terminal is same-cycle, Rollover is a registered one-cycle pulse.
module complex_up_counter_bcd
   import counter_pkg::*;
#(
   parameter int               NUM_DIGITS  = 3,
   parameter logic [BCD_W-1:0] DEFAULT_MAX = 4'd9
)(
   input  logic                        Clk,
   input  logic                        nReset,
   input  logic                        Enable,
   input  logic                        Clear,
   input  logic                        Load,
   input  logic [BCD_W*NUM_DIGITS-1:0] LoadValue,
   input  logic [BCD_W*NUM_DIGITS-1:0] Mode,
   output logic [BCD_W*NUM_DIGITS-1:0] Count,
   output logic                        Terminal,
   output logic                        Rollover
);

   logic [NUM_DIGITS:0]   inc;
   logic [NUM_DIGITS-1:0] at_max;

   assign inc[0] = Enable;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [BCD_W-1:0] max_val;
      assign max_val = mode_to_max(Mode[i*BCD_W +: BCD_W], DEFAULT_MAX);

      bcd_up_digit u_digit (
         .Clk       (Clk),
         .nReset    (nReset),
         .Clear     (Clear),
         .Load      (Load),
         .LoadDigit (LoadValue[i*BCD_W +: BCD_W]),
         .IncIn     (inc[i]),
         .Max       (max_val),
         .Digit     (Count[i*BCD_W +: BCD_W]),
         .AtMax     (at_max[i]),
         .IncOut    (inc[i+1])
      );
   end

   // The carry out of the top digit already implies every digit is at max.
   assign Terminal = inc[NUM_DIGITS] & (&at_max);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Rollover <= 1'b0;
      end else begin
         Rollover <= Terminal & ~Clear & ~Load;
      end
   end

endmodule

// File: tb/tb_complex_up_counter_bcd.sv
// Directed bench for complex_up_counter_bcd with a reference model feeding an expectation queue.
module tb_complex_up_counter_bcd;

   localparam int N = 3;

   typedef struct packed {
      logic [4*N-1:0] count;
      logic           roll;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           enable;
   logic           clear;
   logic           load;
   logic [4*N-1:0] load_value;
   logic [4*N-1:0] mode;
   logic [4*N-1:0] count;
   logic           terminal;
   logic           rollover;

   exp_t  exp_q[$];
   string tag_q[$];

   logic [4*N-1:0] m_cnt;
   logic           m_roll;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   complex_up_counter_bcd #(.NUM_DIGITS(N), .DEFAULT_MAX(4'd9)) dut (
      .Clk       (clk),
      .nReset    (rst_n),
      .Enable    (enable),
      .Clear     (clear),
      .Load      (load),
      .LoadValue (load_value),
      .Mode      (mode),
      .Count     (count),
      .Terminal  (terminal),
      .Rollover  (rollover)
   );

   function automatic logic [3:0] ref_max(input logic [3:0] md);
      case (md)
         4'b1001: return 4'd9;
         4'b0101: return 4'd5;
         4'b0001: return 4'd1;
         default: return 4'd9;
      endcase
   endfunction

   function automatic logic ref_term(input logic [4*N-1:0] c, input logic [4*N-1:0] md, input logic en);
      logic all_max;
      all_max = 1'b1;
      for (int i = 0; i < N; i++)
         if (c[4*i +: 4] < ref_max(md[4*i +: 4])) all_max = 1'b0;
      return en & all_max;
   endfunction

   task automatic chk(input string tag, input logic [4*N-1:0] obs, input logic [4*N-1:0] req);
      total++;
      assert (obs === req) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, req);
   endtask

   // Advance one edge: model the next state, queue it, then compare what the DUT produced.
   task automatic tick(input string tag);
      logic [4*N-1:0] nxt;
      logic           carry;
      logic           term;
      exp_t           e;
      exp_t           got;
      string          t;
      #2;
      term = ref_term(m_cnt, mode, enable);
      chk({tag, "_terminal"}, {{(4*N-1){1'b0}}, terminal}, {{(4*N-1){1'b0}}, term});
      nxt = m_cnt;
      if (clear) begin
         nxt = '0;
      end else if (load) begin
         nxt = load_value;
      end else if (enable) begin
         carry = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (carry) begin
               if (m_cnt[4*i +: 4] >= ref_max(mode[4*i +: 4])) nxt[4*i +: 4] = 4'd0;
               else begin
                  nxt[4*i +: 4] = m_cnt[4*i +: 4] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      e.count = nxt;
      e.roll  = term & ~clear & ~load;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      m_cnt  = nxt;
      m_roll = e.roll;
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      t   = tag_q.pop_front();
      chk({t, "_count"}, count, got.count);
      chk({t, "_rollover"}, {{(4*N-1){1'b0}}, rollover}, {{(4*N-1){1'b0}}, got.roll});
   endtask

   initial begin
      logic [4*N-1:0] mod2_seq [9];
      logic           seen_roll;
      mod2_seq = '{12'h000, 12'h001, 12'h010, 12'h011, 12'h100,
                   12'h101, 12'h110, 12'h111, 12'h000};

      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
      load_value = '0; mode = 12'h999;
      m_cnt = '0; m_roll = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", count, 12'h000);
      chk("reset_rollover", {11'd0, rollover}, 12'h000);
      rst_n = 1'b1;

      // Count a little, then hit reset asynchronously mid-cycle.
      enable = 1'b1;
      repeat (7) tick("pre_reset");
      chk("pre_reset_value", count, 12'h007);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_count", count, 12'h000);
      m_cnt = '0; m_roll = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; enable = 1'b0;
      repeat (5) tick("hold");
      chk("hold_count", count, 12'h000);

      // Minutes-style mix: hundreds mod-10, tens mod-6, ones mod-10.
      mode = {4'b1001, 4'b0101, 4'b1001};
      enable = 1'b1;
      repeat (59) tick("modmix");
      chk("modmix_059", count, 12'h059);
      tick("modmix_wrap");
      chk("modmix_100", count, 12'h100);

      // Full wrap from 999.
      mode = 12'h999; enable = 1'b0; load = 1'b1; load_value = 12'h999;
      tick("load999");
      load = 1'b0; enable = 1'b1;
      #2;
      chk("wrap_terminal", {11'd0, terminal}, 12'h001);
      tick("wrap");
      chk("wrap_count", count, 12'h000);
      chk("wrap_rollover", {11'd0, rollover}, 12'h001);
      tick("post_wrap");
      chk("post_wrap_rollover", {11'd0, rollover}, 12'h000);

      // Ones digit loaded above its mod-6 max wraps and carries.
      mode = {4'b1001, 4'b1001, 4'b0101};
      enable = 1'b0; load = 1'b1; load_value = 12'h038;
      tick("oor_load");
      load = 1'b0; enable = 1'b1;
      tick("oor_inc");
      chk("oor_result", count, 12'h040);

      // Illegal mode code on the ones digit behaves as mod-10.
      mode = {4'b1001, 4'b1001, 4'b0011};
      enable = 1'b0; clear = 1'b1;
      tick("illegal_clear");
      clear = 1'b0; enable = 1'b1;
      repeat (12) tick("illegal");
      chk("illegal_012", count, 12'h012);

      // Priority: Clear over Load over Enable.
      mode = 12'h999; enable = 1'b0; load = 1'b1; load_value = 12'h123;
      tick("prio_load123");
      clear = 1'b1; load = 1'b1; enable = 1'b1; load_value = 12'h777;
      tick("prio_clear");
      chk("prio_clear_count", count, 12'h000);
      clear = 1'b0; load = 1'b1; enable = 1'b1; load_value = 12'h045;
      tick("prio_load");
      chk("prio_load_count", count, 12'h045);
      chk("prio_rollover", {11'd0, rollover}, 12'h000);

      // Binary-like mod-2 chain.
      mode = 12'h111; load = 1'b0; enable = 1'b0; clear = 1'b1;
      tick("mod2_clear");
      clear = 1'b0; enable = 1'b1;
      seen_roll = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick("mod2");
         chk($sformatf("mod2_seq%0d", k), count, mod2_seq[k]);
         if (k < 8 && rollover) seen_roll = 1'b1;
      end
      chk("mod2_final_rollover", {11'd0, rollover}, 12'h001);
      chk("mod2_no_early_rollover", {11'd0, seen_roll}, 12'h000);

      enable = 1'b0;
      tick("final_hold");
      chk("queue_drained", 12'(exp_q.size()), 12'h000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
